// File: rtl/bcd_lap_timer_pkg.sv
// Shared definitions for the BCD lap timer: FSM state encoding, BCD digit
// limits and helpers for the packed time width and preset sanitising.
package bcd_lap_timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [3:0] BCD_MAX9     = 4'd9;
    localparam logic [3:0] BCD_MAX5     = 4'd5;
    localparam int         SEC_TENS_IDX = 2;

    // Packed width: minute digits plus sec tens, sec ones and tenths.
    function automatic int time_width(input int min_digits);
        return 4 * (min_digits + 3);
    endfunction

    function automatic logic [3:0] digit_max(input int idx);
        return (idx == SEC_TENS_IDX) ? BCD_MAX5 : BCD_MAX9;
    endfunction

    function automatic logic [3:0] sat_nibble(input logic [3:0] v, input logic [3:0] lim);
        return (v > lim) ? lim : v;
    endfunction

endpackage

// File: rtl/bcd_lap_timer_digit_cnt.sv
// One BCD digit of the time register: wraps at MAX going up and at 0 going
// down, with a synchronous parallel load that overrides counting.
module bcd_digit_cnt
    import bcd_lap_timer_pkg::*;
#(
    parameter logic [3:0] MAX = BCD_MAX9
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       inc,
    input  logic       dec,
    input  logic       load,
    input  logic [3:0] load_d,
    output logic [3:0] q,
    output logic       carry,
    output logic       borrow
);

    logic [3:0] r_q;

    // NOTE: state registers use non-blocking assignments so every digit in the
    // chain samples its neighbours' pre-edge values on the same clock edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_q <= 4'd0;
        end else if (load) begin
            r_q <= load_d;
        end else if (inc) begin
            r_q <= (r_q == MAX) ? 4'd0 : r_q + 4'd1;
        end else if (dec) begin
            r_q <= (r_q == 4'd0) ? MAX : r_q - 4'd1;
        end
    end

    assign q      = r_q;
    assign carry  = inc && (r_q == MAX);
    assign borrow = dec && (r_q == 4'd0);

endmodule

// File: rtl/bcd_lap_timer.sv
// Up/down BCD stopwatch with preset load, lap capture and expiry, advanced by
// the 0.1 s tick enable. Holds the FSM, lap register and load sanitiser.
module bcd_lap_timer
    import bcd_lap_timer_pkg::*;
#(
    parameter  int MIN_DIGITS = 1,
    localparam int W          = time_width(MIN_DIGITS)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         tick,
    input  logic         start_stop,
    input  logic         clear,
    input  logic         lap,
    input  logic         mode,
    input  logic         load_en,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] time_bcd,
    output logic [W-1:0] lap_bcd,
    output logic         lap_valid,
    output logic         running,
    output logic         expired
);

    localparam int NDIG = MIN_DIGITS + 3;

    state_t         r_state;
    logic           r_run_mode;
    logic           r_running;
    logic           r_expired;
    logic           r_lap_valid;
    logic [W-1:0]   r_lap_bcd;

    logic [W-1:0]    w_time;
    logic [W-1:0]    w_load_d;
    logic [NDIG-1:0] w_carry, w_borrow, w_dig_max, w_dig_zero;
    logic [NDIG-1:0] w_inc_vec, w_dec_vec;
    logic            w_at_end, w_cnt_en, w_load, w_unused;

    // Terminal value depends on direction: all-max going up, all-zero going down.
    assign w_at_end = r_run_mode ? (&w_dig_zero) : (&w_dig_max);
    assign w_cnt_en = (r_state == ST_RUN) && tick && !start_stop && !clear && !w_at_end;
    assign w_load   = clear || (load_en && (r_state != ST_RUN));

    assign w_inc_vec = {w_carry[NDIG-2:0],  w_cnt_en && !r_run_mode};
    assign w_dec_vec = {w_borrow[NDIG-2:0], w_cnt_en &&  r_run_mode};
    assign w_unused  = w_carry[NDIG-1] ^ w_borrow[NDIG-1];

    for (genvar gi = 0; gi < NDIG; gi++) begin : g_digit
        localparam logic [3:0] DMAX = digit_max(gi);

        assign w_load_d[4*gi +: 4] = clear ? 4'd0 : sat_nibble(load_val[4*gi +: 4], DMAX);
        assign w_dig_max[gi]       = (w_time[4*gi +: 4] == DMAX);
        assign w_dig_zero[gi]      = (w_time[4*gi +: 4] == 4'd0);

        bcd_digit_cnt #(.MAX(DMAX)) u_digit (
            .clk    (clk),
            .reset  (reset),
            .inc    (w_inc_vec[gi]),
            .dec    (w_dec_vec[gi]),
            .load   (w_load),
            .load_d (w_load_d[4*gi +: 4]),
            .q      (w_time[4*gi +: 4]),
            .carry  (w_carry[gi]),
            .borrow (w_borrow[gi])
        );
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_run_mode <= 1'b0;
            r_running  <= 1'b0;
            r_expired  <= 1'b0;
        end else if (clear) begin
            r_state   <= ST_IDLE;
            r_running <= 1'b0;
            r_expired <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_PAUSE: begin
                    if (!load_en && start_stop) begin
                        r_state    <= ST_RUN;
                        r_running  <= 1'b1;
                        r_run_mode <= mode;
                    end
                end
                ST_RUN: begin
                    if (start_stop) begin
                        r_state   <= ST_PAUSE;
                        r_running <= 1'b0;
                    end else if (tick && w_at_end) begin
                        r_state   <= ST_DONE;
                        r_running <= 1'b0;
                        r_expired <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (load_en) begin
                        r_state   <= ST_IDLE;
                        r_expired <= 1'b0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Lap captures the pre-tick time; only clear and reset discard it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_lap_bcd   <= '0;
            r_lap_valid <= 1'b0;
        end else if (clear) begin
            r_lap_bcd   <= '0;
            r_lap_valid <= 1'b0;
        end else if (lap && ((r_state == ST_RUN) || (r_state == ST_PAUSE))) begin
            r_lap_bcd   <= w_time;
            r_lap_valid <= 1'b1;
        end
    end

    assign time_bcd  = w_time;
    assign lap_bcd   = r_lap_bcd;
    assign lap_valid = r_lap_valid;
    assign running   = r_running;
    assign expired   = r_expired;

endmodule

// File: tb/tb_bcd_lap_timer.sv
// Self-checking bench for bcd_lap_timer: directed sequences, a vector table and
// randomized traffic against a model that keeps time as a plain tenths count.
module tb_bcd_lap_timer;

    localparam int MD   = 1;
    localparam int NDIG = MD + 3;
    localparam int W    = 4 * NDIG;

    logic         clk = 1'b0;
    logic         reset;
    logic         tick, start_stop, clear, lap, mode, load_en;
    logic [W-1:0] load_val;
    logic [W-1:0] time_bcd, lap_bcd;
    logic         lap_valid, running, expired;

    int n_checks = 0;
    int n_errors = 0;

    bcd_lap_timer #(.MIN_DIGITS(MD)) dut (
        .clk        (clk),
        .reset      (reset),
        .tick       (tick),
        .start_stop (start_stop),
        .clear      (clear),
        .lap        (lap),
        .mode       (mode),
        .load_en    (load_en),
        .load_val   (load_val),
        .time_bcd   (time_bcd),
        .lap_bcd    (lap_bcd),
        .lap_valid  (lap_valid),
        .running    (running),
        .expired    (expired)
    );

    always #5 clk = ~clk;

    // ---------------- reference model (time as integer tenths) ----------------
    typedef enum int {M_IDLE, M_RUN, M_PAUSE, M_DONE} mstate_t;
    mstate_t m_st;
    int      m_t, m_lap;
    bit      m_lapv, m_down;
    int      t_max;

    function automatic int pow10(input int e);
        int p;
        p = 1;
        for (int k = 0; k < e; k++) p = p * 10;
        return p;
    endfunction

    function automatic logic [W-1:0] to_bcd(input int t);
        logic [W-1:0] r;
        int m;
        r       = '0;
        r[3:0]  = 4'(t % 10);
        r[7:4]  = 4'((t / 10) % 10);
        r[11:8] = 4'((t / 100) % 6);
        m = t / 600;
        for (int d = 0; d < MD; d++) begin
            r[12+4*d +: 4] = 4'(m % 10);
            m = m / 10;
        end
        return r;
    endfunction

    function automatic int from_bcd(input logic [W-1:0] v);
        int dg[NDIG];
        int n, lim, m;
        for (int i = 0; i < NDIG; i++) begin
            n   = int'(v[4*i +: 4]);
            lim = (i == 2) ? 5 : 9;
            dg[i] = (n > lim) ? lim : n;
        end
        m = 0;
        for (int d = 0; d < MD; d++) m = m + dg[3+d] * pow10(d);
        return dg[0] + 10 * dg[1] + 100 * dg[2] + 600 * m;
    endfunction

    task automatic model_reset();
        m_st = M_IDLE; m_t = 0; m_lap = 0; m_lapv = 0; m_down = 0;
    endtask

    task automatic model_step(input bit tk, ss, clr, lp, md, ld, input logic [W-1:0] lv);
        if (clr) begin
            m_st = M_IDLE; m_t = 0; m_lap = 0; m_lapv = 0;
        end else begin
            if (lp && (m_st == M_RUN || m_st == M_PAUSE)) begin
                m_lap = m_t; m_lapv = 1;
            end
            if (ld && m_st != M_RUN) begin
                m_t = from_bcd(lv);
                if (m_st == M_DONE) m_st = M_IDLE;
            end else if (ss && m_st != M_DONE) begin
                if (m_st == M_RUN) m_st = M_PAUSE;
                else begin m_st = M_RUN; m_down = md; end
            end else if (tk && m_st == M_RUN) begin
                if (!m_down) begin
                    if (m_t == t_max) m_st = M_DONE; else m_t = m_t + 1;
                end else begin
                    if (m_t == 0) m_st = M_DONE; else m_t = m_t - 1;
                end
            end
        end
    endtask

    // ---------------- stimulus and checking helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input bit tk, ss, clr, lp, md, ld, input logic [W-1:0] lv);
        tick = tk; start_stop = ss; clear = clr; lap = lp; mode = md; load_en = ld; load_val = lv;
        @(posedge clk);
        model_step(tk, ss, clr, lp, md, ld, lv);
        #1;
        tick = 0; start_stop = 0; clear = 0; lap = 0; load_en = 0;
    endtask

    task automatic check_model(input string tag);
        check({tag, ".time"},    32'(time_bcd),  32'(to_bcd(m_t)));
        check({tag, ".lap"},     32'(lap_bcd),   32'(to_bcd(m_lap)));
        check({tag, ".lapv"},    32'(lap_valid), 32'(m_lapv));
        check({tag, ".running"}, 32'(running),   32'(m_st == M_RUN));
        check({tag, ".expired"}, 32'(expired),   32'(m_st == M_DONE));
    endtask

    typedef struct {
        bit           tk, ss, clr, lp, md, ld;
        logic [W-1:0] lv;
        logic [W-1:0] e_time, e_lap;
        bit           e_lapv, e_run, e_exp;
    } vec_t;

    function automatic vec_t mk(input bit tk, ss, clr, lp, md, ld, input logic [W-1:0] lv,
                                input logic [W-1:0] et, el, input bit elv, er, ee);
        vec_t v;
        v.tk = tk; v.ss = ss; v.clr = clr; v.lp = lp; v.md = md; v.ld = ld; v.lv = lv;
        v.e_time = et; v.e_lap = el; v.e_lapv = elv; v.e_run = er; v.e_exp = ee;
        return v;
    endfunction

    vec_t tbl[$];

    initial begin
        t_max = 600 * pow10(MD) - 1;
        tick = 0; start_stop = 0; clear = 0; lap = 0; mode = 0; load_en = 0; load_val = '0;
        reset = 1'b1;
        model_reset();
        #2 reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset.time",    32'(time_bcd),  0);
        check("reset.lap",     32'(lap_bcd),   0);
        check("reset.lapv",    32'(lap_valid), 0);
        check("reset.running", 32'(running),   0);
        check("reset.expired", 32'(expired),   0);
        @(negedge clk);
        reset = 1'b1;

        // Count up 600 ticks: 1:00.0
        drive(0, 1, 0, 0, 0, 0, '0);
        for (int i = 0; i < 600; i++) drive(1, 0, 0, 0, 0, 0, '0);
        check("up600.time",    32'(time_bcd), 32'h1000);
        check("up600.running", 32'(running),  1);

        // Lap with a same-cycle tick captures the pre-tick value
        drive(0, 0, 1, 0, 0, 0, '0);
        drive(0, 1, 0, 0, 0, 0, '0);
        for (int i = 0; i < 34; i++) drive(1, 0, 0, 0, 0, 0, '0);
        check("lap.pre_time", 32'(time_bcd), 32'h0034);
        drive(1, 0, 0, 1, 0, 0, '0);
        check("lap.lap",  32'(lap_bcd),   32'h0034);
        check("lap.time", 32'(time_bcd),  32'h0035);
        check("lap.lapv", 32'(lap_valid), 1);
        drive(0, 0, 1, 0, 0, 0, '0);
        check("clear.time",    32'(time_bcd),  0);
        check("clear.lap",     32'(lap_bcd),   0);
        check("clear.lapv",    32'(lap_valid), 0);
        check("clear.running", 32'(running),   0);

        // Vector table: countdown to expiry, sanitised load, RUN-load ignored,
        // start+tick collision, lap in PAUSE, up-terminal expiry, DONE exits.
        tbl.push_back(mk(0,0,0,0,0,1,16'h0010, 16'h0010,16'h0000,0,0,0));
        tbl.push_back(mk(0,1,0,0,1,0,16'h0000, 16'h0010,16'h0000,0,1,0));
        tbl.push_back(mk(1,0,0,0,1,0,16'h0000, 16'h0009,16'h0000,0,1,0));
        tbl.push_back(mk(1,0,0,0,1,0,16'h0000, 16'h0008,16'h0000,0,1,0));
        tbl.push_back(mk(1,0,0,0,0,0,16'h0000, 16'h0007,16'h0000,0,1,0));
        for (int k = 6; k >= 0; k--)
            tbl.push_back(mk(1,0,0,0,0,0,16'h0000, W'(k),16'h0000,0,1,0));
        tbl.push_back(mk(1,0,0,0,0,0,16'h0000, 16'h0000,16'h0000,0,0,1));
        tbl.push_back(mk(0,1,0,0,0,0,16'h0000, 16'h0000,16'h0000,0,0,1));
        tbl.push_back(mk(0,0,0,0,0,1,16'hFAFF, 16'h9599,16'h0000,0,0,0));
        tbl.push_back(mk(0,1,0,0,0,0,16'h0000, 16'h9599,16'h0000,0,1,0));
        tbl.push_back(mk(0,0,0,0,0,1,16'h0000, 16'h9599,16'h0000,0,1,0));
        tbl.push_back(mk(1,1,0,0,0,0,16'h0000, 16'h9599,16'h0000,0,0,0));
        tbl.push_back(mk(1,0,0,0,0,0,16'h0000, 16'h9599,16'h0000,0,0,0));
        tbl.push_back(mk(0,0,0,1,0,0,16'h0000, 16'h9599,16'h9599,1,0,0));
        tbl.push_back(mk(0,1,0,0,0,0,16'h0000, 16'h9599,16'h9599,1,1,0));
        tbl.push_back(mk(1,0,0,0,0,0,16'h0000, 16'h9599,16'h9599,1,0,1));
        tbl.push_back(mk(1,0,0,0,0,0,16'h0000, 16'h9599,16'h9599,1,0,1));
        tbl.push_back(mk(0,1,0,0,0,0,16'h0000, 16'h9599,16'h9599,1,0,1));
        tbl.push_back(mk(0,0,0,1,0,0,16'h0000, 16'h9599,16'h9599,1,0,1));
        tbl.push_back(mk(0,0,0,0,0,1,16'h0123, 16'h0123,16'h9599,1,0,0));
        tbl.push_back(mk(0,0,1,0,0,0,16'h0000, 16'h0000,16'h0000,0,0,0));
        foreach (tbl[i]) begin
            drive(tbl[i].tk, tbl[i].ss, tbl[i].clr, tbl[i].lp, tbl[i].md, tbl[i].ld, tbl[i].lv);
            check($sformatf("vec%0d.time", i),    32'(time_bcd),  32'(tbl[i].e_time));
            check($sformatf("vec%0d.lap", i),     32'(lap_bcd),   32'(tbl[i].e_lap));
            check($sformatf("vec%0d.lapv", i),    32'(lap_valid), 32'(tbl[i].e_lapv));
            check($sformatf("vec%0d.running", i), 32'(running),   32'(tbl[i].e_run));
            check($sformatf("vec%0d.expired", i), 32'(expired),   32'(tbl[i].e_exp));
        end

        // Asynchronous reset between clock edges while running
        drive(0, 1, 0, 0, 0, 0, '0);
        for (int i = 0; i < 5; i++) drive(1, 0, 0, 0, 0, 0, '0);
        #3 reset = 1'b0;
        model_reset();
        #1;
        check("areset.time",    32'(time_bcd), 0);
        check("areset.running", 32'(running),  0);
        @(negedge clk);
        #2 reset = 1'b1;
        drive(1, 0, 0, 0, 0, 0, '0);
        check("areset.idle_time",    32'(time_bcd), 0);
        check("areset.idle_running", 32'(running),  0);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            logic [W-1:0] lv;
            lv = ($urandom_range(0, 2) == 0) ? W'($urandom_range(0, 40)) : W'($urandom);
            drive($urandom_range(0, 1) == 1,
                  $urandom_range(0, 19) == 0,
                  $urandom_range(0, 199) == 0,
                  $urandom_range(0, 9) == 0,
                  $urandom_range(0, 1) == 1,
                  $urandom_range(0, 39) == 0,
                  lv);
            check_model($sformatf("rnd%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
